// File: rtl/gig_eth_pkg.sv
// gig_eth_pkg: shared arbiter state encoding and AXIS byte-lane width for the gigabit TX path
package gig_eth_pkg;
    localparam int AXIS_DW = 8;
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_PASS  = 2'd1,
        ARB_DRAIN = 2'd2,
        ARB_GAP   = 2'd3
    } arb_state_e;
endpackage

// File: rtl/gig_eth_sat_cnt.sv
// gig_eth_sat_cnt: saturating event counter that sticks at all-ones
module gig_eth_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             tx_clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge tx_clk) begin
        if (reset)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/gig_eth_tx_arb.sv
// gig_eth_tx_arb: packet-granular two-source arbiter feeding the gigabit MAC TX AXIS port
module gig_eth_tx_arb
    import gig_eth_pkg::*;
#(
    parameter int HI_BURST_MAX = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 16
) (
    input  logic               tx_clk,
    input  logic               reset,
    input  logic [AXIS_DW-1:0] s0_axis_tdata,
    input  logic               s0_axis_tvalid,
    input  logic               s0_axis_tlast,
    input  logic               s0_axis_tuser,
    output logic               s0_axis_tready,
    input  logic [AXIS_DW-1:0] s1_axis_tdata,
    input  logic               s1_axis_tvalid,
    input  logic               s1_axis_tlast,
    input  logic               s1_axis_tuser,
    output logic               s1_axis_tready,
    output logic [AXIS_DW-1:0] m_axis_mac_tdata,
    output logic               m_axis_mac_tvalid,
    output logic               m_axis_mac_tlast,
    output logic               m_axis_mac_tuser,
    input  logic               m_axis_mac_tready,
    output logic               grant_sel,
    output logic               busy,
    output logic [CNT_W-1:0]   frames0_cnt,
    output logic [CNT_W-1:0]   frames1_cnt,
    output logic [CNT_W-1:0]   underrun0_cnt,
    output logic [CNT_W-1:0]   underrun1_cnt
);
    arb_state_e         state, state_nxt;
    logic               grant_nxt;
    logic [3:0]         hi_burst_cnt, hi_burst_nxt, gap_cnt, gap_nxt;
    logic [AXIS_DW-1:0] src_tdata;
    logic               src_tvalid, src_tlast, src_tuser, src_tready;
    logic               req1_win, frame_done, underrun;

    assign src_tdata      = grant_sel ? s1_axis_tdata : s0_axis_tdata;
    assign src_tvalid     = grant_sel ? s1_axis_tvalid : s0_axis_tvalid;
    assign src_tlast      = grant_sel ? s1_axis_tlast : s0_axis_tlast;
    assign src_tuser      = grant_sel ? s1_axis_tuser : s0_axis_tuser;
    assign req1_win       = s1_axis_tvalid && (hi_burst_cnt < 4'(HI_BURST_MAX) || !s0_axis_tvalid);
    assign s0_axis_tready = src_tready && !grant_sel;
    assign s1_axis_tready = src_tready && grant_sel;
    assign busy           = state != ARB_IDLE;

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            grant_sel    <= 1'b0;
            hi_burst_cnt <= '0;
            gap_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            grant_sel    <= grant_nxt;
            hi_burst_cnt <= hi_burst_nxt;
            gap_cnt      <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        grant_nxt         = grant_sel;
        hi_burst_nxt      = hi_burst_cnt;
        gap_nxt           = gap_cnt;
        m_axis_mac_tdata  = '0;
        m_axis_mac_tvalid = 1'b0;
        m_axis_mac_tlast  = 1'b0;
        m_axis_mac_tuser  = 1'b0;
        src_tready        = 1'b0;
        frame_done        = 1'b0;
        underrun          = 1'b0;
        case (state)
            ARB_IDLE: begin
                // req1 can only win with s0 waiting while below the burst cap, so the increment never overshoots
                if (req1_win) begin
                    grant_nxt    = 1'b1;
                    hi_burst_nxt = s0_axis_tvalid ? hi_burst_cnt + 4'd1 : 4'd0;
                    state_nxt    = ARB_PASS;
                end else if (s0_axis_tvalid) begin
                    grant_nxt    = 1'b0;
                    hi_burst_nxt = 4'd0;
                    state_nxt    = ARB_PASS;
                end
            end
            ARB_PASS: begin
                m_axis_mac_tvalid = 1'b1;
                if (src_tvalid) begin
                    m_axis_mac_tdata = src_tdata;
                    m_axis_mac_tlast = src_tlast;
                    m_axis_mac_tuser = src_tuser;
                    src_tready       = m_axis_mac_tready;
                    frame_done       = m_axis_mac_tready && src_tlast;
                    state_nxt        = frame_done ? ARB_GAP : ARB_PASS;
                    gap_nxt          = frame_done ? 4'd1 : gap_cnt;
                end else begin
                    // keep tvalid high with a poisoned byte so the MAC aborts rather than ending the frame
                    m_axis_mac_tuser = 1'b1;
                    underrun         = 1'b1;
                    state_nxt        = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                src_tready = 1'b1;
                state_nxt  = src_tvalid && src_tlast ? ARB_GAP : ARB_DRAIN;
                gap_nxt    = src_tvalid && src_tlast ? 4'd1 : gap_cnt;
            end
            ARB_GAP: begin
                state_nxt = gap_cnt == 4'(GAP_CYCLES) ? ARB_IDLE : ARB_GAP;
                gap_nxt   = gap_cnt == 4'(GAP_CYCLES) ? 4'd0 : gap_cnt + 4'd1;
            end
        endcase
    end

    gig_eth_sat_cnt #(.CNT_W(CNT_W)) u_frames0 (
        .tx_clk (tx_clk),
        .reset  (reset),
        .inc    (frame_done && !grant_sel),
        .cnt    (frames0_cnt)
    );

    gig_eth_sat_cnt #(.CNT_W(CNT_W)) u_frames1 (
        .tx_clk (tx_clk),
        .reset  (reset),
        .inc    (frame_done && grant_sel),
        .cnt    (frames1_cnt)
    );

    gig_eth_sat_cnt #(.CNT_W(CNT_W)) u_underrun0 (
        .tx_clk (tx_clk),
        .reset  (reset),
        .inc    (underrun && !grant_sel),
        .cnt    (underrun0_cnt)
    );

    gig_eth_sat_cnt #(.CNT_W(CNT_W)) u_underrun1 (
        .tx_clk (tx_clk),
        .reset  (reset),
        .inc    (underrun && grant_sel),
        .cnt    (underrun1_cnt)
    );
endmodule
